// File: rtl/adc_spi_master_if.sv
// Command-side and SPI-pin signals of adc_spi_master. The master modport is the
// SPI master's view; slave is the view of the command processor plus the ADC pins.
interface adc_spi_master_if;
    logic [7:0] spitx;
    logic       spitxdv;
    logic       spitxready;
    logic [7:0] spirx;
    logic       spirxdv;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;

    modport master (
        input  spitx, spitxdv, spi_miso,
        output spitxready, spirx, spirxdv, spi_sclk, spi_mosi
    );
    modport slave (
        output spitx, spitxdv, spi_miso,
        input  spitxready, spirx, spirxdv, spi_sclk, spi_mosi
    );
endinterface

// File: rtl/adc_spi_master.sv
// Byte-wide SPI master (SCLK/MOSI only, CS owned upstream), modes 0..3, SCLK = clk/(2H).
// Define ADC_SPI_LSB_FIRST_EN to shift both directions LSB first; default is MSB first.
module adc_spi_master #(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input logic               clk,
    input logic               rstn,
    adc_spi_master_if.master  bus
);
`ifdef ADC_SPI_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif
    localparam bit        CPOL     = SPI_MODE[1];
    localparam bit        CPHA     = SPI_MODE[0];
    localparam logic [7:0] DIV_LAST = 8'(CLKS_PER_HALF_BIT - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state_q;
    logic [7:0] div_q;
    logic [4:0] edge_q;
    logic [7:0] tx_q, rx_q, spirx_q;
    logic       sclk_q, mosi_q, ready_q, rxdv_q;

    logic       leading, drive_edge, sample_edge, tx_bit, first_bit;
    logic [7:0] tx_shift, rx_shift, first_load;

    // edge_q counts edges already made, so the next edge is k = edge_q+1 (odd = leading)
    always_comb begin
        leading = ~edge_q[0];
        if (LSB_FIRST) begin
            tx_bit     = tx_q[0];
            tx_shift   = {1'b0, tx_q[7:1]};
            rx_shift   = {bus.spi_miso, rx_q[7:1]};
            first_bit  = bus.spitx[0];
            first_load = {1'b0, bus.spitx[7:1]};
        end else begin
            tx_bit     = tx_q[7];
            tx_shift   = {tx_q[6:0], 1'b0};
            rx_shift   = {rx_q[6:0], bus.spi_miso};
            first_bit  = bus.spitx[7];
            first_load = {bus.spitx[6:0], 1'b0};
        end
        if (CPHA) begin
            drive_edge  = leading;
            sample_edge = ~leading;
        end else begin
            drive_edge  = ~leading && (edge_q != 5'd15);
            sample_edge = leading;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            div_q   <= 8'd0;
            edge_q  <= 5'd0;
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            spirx_q <= 8'h00;
            sclk_q  <= CPOL;
            mosi_q  <= 1'b0;
            ready_q <= 1'b1;
            rxdv_q  <= 1'b0;
        end else begin
            rxdv_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.spitxdv) begin
                    state_q <= SHIFT;
                    ready_q <= 1'b0;
                    // the accept cycle is divider step 0, so edge k lands at T+k*H
                    div_q   <= 8'd1;
                    edge_q  <= 5'd0;
                    if (CPHA) begin
                        tx_q <= bus.spitx;
                    end else begin
                        mosi_q <= first_bit;
                        tx_q   <= first_load;
                    end
                end
                SHIFT: begin
                    if (edge_q == 5'd16) begin
                        state_q <= DONE;
                        spirx_q <= rx_q;
                        rxdv_q  <= 1'b1;
                        ready_q <= 1'b1;
                        sclk_q  <= CPOL;
                    end else if (div_q == DIV_LAST) begin
                        div_q  <= 8'd0;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + 5'd1;
                        if (drive_edge) begin
                            mosi_q <= tx_bit;
                            tx_q   <= tx_shift;
                        end
                        if (sample_edge) rx_q <= rx_shift;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.spitxready = ready_q;
    assign bus.spirx      = spirx_q;
    assign bus.spirxdv    = rxdv_q;
    assign bus.spi_sclk   = sclk_q;
    assign bus.spi_mosi   = mosi_q;
endmodule

// File: tb/tb_adc_spi_master.sv
// Directed bench: mode 0 / H=2 and mode 3 / H=4 instances, a polled SPI slave,
// table of transfers plus hand sequences for ignored requests and mid-transfer reset.
module tb_adc_spi_master;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    adc_spi_master_if if0 ();
    adc_spi_master_if if1 ();

    adc_spi_master #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(2)) u0 (.clk(clk), .rstn(rstn), .bus(if0));
    adc_spi_master #(.SPI_MODE(3), .CLKS_PER_HALF_BIT(4)) u1 (.clk(clk), .rstn(rstn), .bus(if1));

    logic [7:0] txb [2];
    logic [1:0] dv   = 2'b00;
    logic [1:0] miso = 2'b00;
    logic [1:0] rdy, rxdv, sclk, mosi;
    logic [7:0] rx [2];

    assign if0.spitx = txb[0];  assign if0.spitxdv = dv[0];  assign if0.spi_miso = miso[0];
    assign if1.spitx = txb[1];  assign if1.spitxdv = dv[1];  assign if1.spi_miso = miso[1];
    assign rdy  = {if1.spitxready, if0.spitxready};
    assign rxdv = {if1.spirxdv,    if0.spirxdv};
    assign sclk = {if1.spi_sclk,   if0.spi_sclk};
    assign mosi = {if1.spi_mosi,   if0.spi_mosi};
    assign rx[0] = if0.spirx;
    assign rx[1] = if1.spirx;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    function automatic logic [7:0] order(input logic [7:0] b);
`ifdef ADC_SPI_LSB_FIRST_EN
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
`else
        return b;
`endif
    endfunction

    // One transfer on instance d. mseq is MISO in wire order (first bit in mseq[7]).
    // inj: cycle at which a stray 0xFF request is pulsed; rst_at: cycle of a reset pulse.
    task automatic xfer(input int d, input logic [7:0] tx, input logic [7:0] mseq,
                        input logic [7:0] emosi, input logic [7:0] erx, input int lat,
                        input int inj, input int rst_at, input string nm, output int edges);
        int first, pulses, rises, w;
        logic [7:0] sh, mcap;
        logic prev, rdy_bad, aborted;
        w = 0;
        while (!rdy[d] && w < 200) begin @(negedge clk); w++; end
        chk({nm, " ready wait"}, rdy[d], 1'b1);
        @(negedge clk);
        sh = mseq;
        if (d == 0) begin miso[d] = sh[7]; sh = sh << 1; end
        txb[d] = tx; dv[d] = 1'b1;
        prev = sclk[d]; first = 0; pulses = 0; rises = 0; edges = 0; mcap = 8'h00;
        rdy_bad = 1'b0; aborted = 1'b0;
        for (int n = 1; n <= lat + 2; n++) begin
            @(negedge clk);
            dv[d] = (n == inj);
            if (n == inj) txb[d] = 8'hFF;
            if (n == 1) chk({nm, " ready drop"}, rdy[d], 1'b0);
            if (sclk[d] != prev) begin
                edges++;
                if (sclk[d]) begin rises++; mcap = {mcap[6:0], mosi[d]}; end
                else begin miso[d] = sh[7]; sh = sh << 1; end
                prev = sclk[d];
            end
            if (rxdv[d]) begin pulses++; if (first == 0) first = n; end
            if (n > 1 && n < lat && rdy[d] && !aborted) rdy_bad = 1'b1;
            if (n == rst_at) begin
                rstn = 1'b0; aborted = 1'b1;
                #1;
                chk({nm, " rst ready"}, rdy[d], 1'b1);
                chk({nm, " rst sclk"}, sclk[d], (d == 1) ? 1'b1 : 1'b0);
                chk({nm, " rst rxdv"}, rxdv[d], 1'b0);
                chk({nm, " rst spirx"}, rx[d], 8'h00);
                chk({nm, " rst mosi"}, mosi[d], 1'b0);
                prev = sclk[d];
            end
            if (n == rst_at + 1) rstn = 1'b1;
        end
        if (aborted) begin
            chk({nm, " no rxdv after abort"}, pulses, 0);
        end else begin
            chk({nm, " latency"}, first, lat);
            chk({nm, " rxdv pulses"}, pulses, 1);
            chk({nm, " spirx"}, rx[d], order(erx));
            chk({nm, " mosi bits"}, mcap, order(emosi));
            chk({nm, " sclk rises"}, rises, 8);
            chk({nm, " ready held low"}, rdy_bad, 1'b0);
            chk({nm, " ready after"}, rdy[d], 1'b1);
        end
    endtask

    typedef struct {
        int d;
        logic [7:0] tx, mseq, emosi, erx;
        int lat;
    } vec_t;

    vec_t vt [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, tot;
        vt[0] = '{0, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 33};
        vt[1] = '{0, 8'h00, 8'hFF, 8'h00, 8'hFF, 33};
        vt[2] = '{0, 8'hFF, 8'h00, 8'hFF, 8'h00, 33};
        vt[3] = '{0, 8'h01, 8'h80, 8'h01, 8'h80, 33};
        vt[4] = '{1, 8'h81, 8'hF0, 8'h81, 8'hF0, 65};
        vt[5] = '{1, 8'h3C, 8'h0F, 8'h3C, 8'h0F, 65};
        vt[6] = '{1, 8'h6E, 8'h99, 8'h6E, 8'h99, 65};
        txb[0] = 8'h00; txb[1] = 8'h00;

        #23;
        chk("reset ready0", rdy[0], 1'b1);
        chk("reset rxdv0",  rxdv[0], 1'b0);
        chk("reset spirx0", rx[0], 8'h00);
        chk("reset sclk0",  sclk[0], 1'b0);
        chk("reset mosi0",  mosi[0], 1'b0);
        chk("reset sclk1",  sclk[1], 1'b1);
        chk("reset ready1", rdy[1], 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++)
            xfer(vt[i].d, vt[i].tx, vt[i].mseq, vt[i].emosi, vt[i].erx, vt[i].lat, 0, 0,
                 $sformatf("vec%0d", i), e);

        // stray request at edge 5 (cycle 5H) and in the DONE cycle
        xfer(0, 8'h3C, 8'hA5, 8'h3C, 8'hA5, 33, 10, 0, "inj edge5", e);
        xfer(0, 8'h96, 8'h69, 8'h96, 8'h69, 33, 33, 0, "inj done", e);

        // reset at edge 9, then a clean transfer
        xfer(0, 8'hC3, 8'h55, 8'hC3, 8'h55, 33, 0, 18, "abort", e);
        xfer(0, 8'h5A, 8'h96, 8'h5A, 8'h96, 33, 0, 0, "post abort", e);

        // three back-to-back bytes
        tot = 0;
        xfer(0, 8'h80, 8'h11, 8'h80, 8'h11, 33, 0, 0, "b2b0", e); tot += e;
        xfer(0, 8'h0A, 8'h22, 8'h0A, 8'h22, 33, 0, 0, "b2b1", e); tot += e;
        xfer(0, 8'h00, 8'h33, 8'h00, 8'h33, 33, 0, 0, "b2b2", e); tot += e;
        chk("b2b total sclk edges", tot, 48);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
